// File: rtl/spi_slave_shift.sv
// SPI mode-0 peripheral shift engine, LSB first, oversampled in the system clock domain.
// Receives an N-bit frame on MOSI while shifting a buffered word out on MISO.
module spi_slave_shift #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            spi_data_len_i,
    input  logic                  sclk_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  underrun_o,
    output logic                  frame_err_o
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDone
    } state_e;

    // Synchronizers; the extra *_prev_q flop provides edge detection.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [CntW-1:0]        len_q;
    logic [DATA_WIDTH-1:0]  tx_buf_q;
    logic                   tx_full_q;
    logic [DATA_WIDTH-1:0]  tx_shift_q;
    logic [DATA_WIDTH-1:0]  rx_shift_q;
    logic [DATA_WIDTH-1:0]  rx_data_q;
    logic                   rx_valid_q;
    logic                   underrun_q;
    logic                   frame_err_q;
    logic                   miso_q;
    logic                   miso_oe_q;

    logic                   tx_wr;
    logic [CntW-1:0]        frame_len;
    logic [DATA_WIDTH-1:0]  rx_shift_d;
    logic                   last_bit;
    int unsigned            len_bits;

    assign tx_wr = tx_valid_i & ~tx_full_q;

    always_comb begin
        len_bits = (int'(spi_data_len_i) + 1) * 8;
        if (len_bits > DATA_WIDTH) begin
            len_bits = DATA_WIDTH;
        end
        frame_len = CntW'(len_bits);
        // New bit enters at N-1, so after N samples the first bit sits at bit 0.
        rx_shift_d = (rx_shift_q >> 1)
                   | ({{(DATA_WIDTH-1){1'b0}}, mosi_s} << (len_q - CntW'(1)));
        last_bit   = ((cnt_q + CntW'(1)) == len_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= CntW'(8);
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (tx_wr) begin
                tx_buf_q  <= tx_data_i;
                tx_full_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    if (cs_fall) begin
                        state_q    <= StActive;
                        len_q      <= frame_len;
                        cnt_q      <= '0;
                        rx_shift_q <= '0;
                        miso_oe_q  <= 1'b1;
                        if (tx_full_q) begin
                            tx_shift_q <= tx_buf_q;
                            miso_q     <= tx_buf_q[0];
                            tx_full_q  <= 1'b0;
                        end else if (tx_wr) begin
                            // Write and frame start together: the new word goes straight out.
                            tx_shift_q <= tx_data_i;
                            miso_q     <= tx_data_i[0];
                            tx_full_q  <= 1'b0;
                        end else begin
                            tx_shift_q <= '0;
                            miso_q     <= 1'b0;
                            underrun_q <= 1'b1;
                        end
                    end
                end
                StActive: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        state_q     <= StIdle;
                        miso_q      <= 1'b0;
                        miso_oe_q   <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift_q <= rx_shift_d;
                        cnt_q      <= cnt_q + CntW'(1);
                        if (last_bit) begin
                            rx_data_q  <= rx_shift_d;
                            rx_valid_q <= 1'b1;
                            state_q    <= StDone;
                            miso_q     <= 1'b0;
                        end
                    end else if (sclk_fall) begin
                        tx_shift_q <= tx_shift_q >> 1;
                        miso_q     <= tx_shift_q[1];
                    end
                end
                StDone: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        state_q   <= StIdle;
                        miso_oe_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign miso_o      = miso_q;
    assign miso_oe_o   = miso_oe_q;
    assign tx_ready_o  = ~tx_full_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign underrun_o  = underrun_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_slave_shift.sv
// Directed bench for spi_slave_shift: acts as an SPI mode-0 master and checks both directions.
module tb_spi_slave_shift;

    logic        clk;
    logic        rst_n;
    logic [1:0]  spi_data_len;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        underrun;
    logic        frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rxv    = 0;
    int n_und    = 0;
    int n_ferr   = 0;

    spi_slave_shift #(
        .DATA_WIDTH (32),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .spi_data_len_i(spi_data_len),
        .sclk_i        (sclk),
        .cs_n_i        (cs_n),
        .mosi_i        (mosi),
        .miso_o        (miso),
        .miso_oe_o     (miso_oe),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .underrun_o    (underrun),
        .frame_err_o   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid)  n_rxv  = n_rxv + 1;
        if (underrun)  n_und  = n_und + 1;
        if (frame_err) n_ferr = n_ferr + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic write_tx(input logic [31:0] w);
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Master side: 8 clk per SCLK half period, MOSI changes on the falling edge.
    task automatic xfer(input int ncyc, input logic [31:0] mosi_w, output logic [31:0] miso_w,
                        output logic oe_mid, output logic rdy_mid);
        miso_w  = '0;
        oe_mid  = 1'b0;
        rdy_mid = 1'b0;
        @(negedge clk);
        cs_n = 1'b0;
        mosi = mosi_w[0];
        repeat (8) @(negedge clk);
        for (int i = 0; i < ncyc; i++) begin
            sclk = 1'b1;
            if (i < 32) miso_w[i] = miso;
            if (i == 0) begin
                oe_mid  = miso_oe;
                rdy_mid = tx_ready;
            end
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            mosi = (i + 1 < 32) ? mosi_w[i+1] : 1'b0;
            repeat (8) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    logic [31:0] mw;
    logic        oe_m, rdy_m;
    int          rxv_b, und_b, ferr_b;

    initial begin
        rst_n        = 1'b0;
        spi_data_len = 2'b00;
        sclk         = 1'b0;
        cs_n         = 1'b1;
        mosi         = 1'b0;
        tx_data      = '0;
        tx_valid     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8-bit frame
        write_tx(32'h0000_00A5);
        check("f8_tx_ready_low", 32'(tx_ready), 32'd0);
        spi_data_len = 2'b00;
        rxv_b = n_rxv; und_b = n_und;
        xfer(8, 32'h0000_003C, mw, oe_m, rdy_m);
        check("f8_miso", mw, 32'h0000_00A5);
        check("f8_oe_mid", 32'(oe_m), 32'd1);
        check("f8_rx_data", rx_data, 32'h0000_003C);
        check("f8_rx_valid_cnt", 32'(n_rxv - rxv_b), 32'd1);
        check("f8_underrun_cnt", 32'(n_und - und_b), 32'd0);
        check("f8_oe_after", 32'(miso_oe), 32'd0);

        // 32-bit frame
        write_tx(32'hDEAD_BEEF);
        check("f32_tx_ready_low", 32'(tx_ready), 32'd0);
        spi_data_len = 2'b11;
        xfer(32, 32'h1234_5678, mw, oe_m, rdy_m);
        check("f32_tx_ready_mid", 32'(rdy_m), 32'd1);
        check("f32_miso", mw, 32'hDEAD_BEEF);
        check("f32_rx_data", rx_data, 32'h1234_5678);

        // 16-bit frame, empty tx buffer
        spi_data_len = 2'b01;
        rxv_b = n_rxv; und_b = n_und;
        xfer(16, 32'h0000_BEEF, mw, oe_m, rdy_m);
        check("f16_underrun_cnt", 32'(n_und - und_b), 32'd1);
        check("f16_miso", mw, 32'h0000_0000);
        check("f16_rx_data", rx_data, 32'h0000_BEEF);
        check("f16_rx_valid_cnt", 32'(n_rxv - rxv_b), 32'd1);

        // Aborted 24-bit frame, then a full one
        spi_data_len = 2'b10;
        rxv_b = n_rxv; ferr_b = n_ferr;
        xfer(10, 32'h00FF_FFFF, mw, oe_m, rdy_m);
        check("abort_frame_err_cnt", 32'(n_ferr - ferr_b), 32'd1);
        check("abort_rx_valid_cnt", 32'(n_rxv - rxv_b), 32'd0);
        check("abort_rx_data_kept", rx_data, 32'h0000_BEEF);
        check("abort_oe_after", 32'(miso_oe), 32'd0);
        xfer(24, 32'h00AB_CDEF, mw, oe_m, rdy_m);
        check("f24_rx_data", rx_data, 32'h00AB_CDEF);

        // 8-bit frame clocked 12 times
        write_tx(32'h0000_0096);
        spi_data_len = 2'b00;
        rxv_b = n_rxv; ferr_b = n_ferr;
        xfer(12, 32'h0000_0F5A, mw, oe_m, rdy_m);
        check("over_rx_valid_cnt", 32'(n_rxv - rxv_b), 32'd1);
        check("over_miso", mw, 32'h0000_0096);
        check("over_rx_data", rx_data, 32'h0000_005A);
        check("over_frame_err_cnt", 32'(n_ferr - ferr_b), 32'd0);

        // Reset during bit 5 of a 16-bit frame
        spi_data_len = 2'b01;
        @(negedge clk);
        cs_n = 1'b0;
        mosi = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            repeat (8) @(negedge clk);
        end
        write_tx(32'h0000_7777);
        check("mid_tx_ready_low", 32'(tx_ready), 32'd0);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", 32'(miso), 32'd0);
        check("mid_rst_oe", 32'(miso_oe), 32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_rx_data", rx_data, 32'd0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rxv_b = n_rxv; ferr_b = n_ferr;
        xfer(16, 32'h0000_5555, mw, oe_m, rdy_m);
        check("post_rst_rx_data", rx_data, 32'h0000_5555);
        check("post_rst_rx_valid_cnt", 32'(n_rxv - rxv_b), 32'd1);
        check("post_rst_frame_err_cnt", 32'(n_ferr - ferr_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
